// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: drives register-file read addresses, bypasses
// same-cycle writeback into the operands and registers the ID/EX pipeline slot.
module operand_fetch_stage #(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int pc_width   = 9,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [data_width-1:0] if_instr,
    input  logic [pc_width-1:0]   if_pc,
    output logic                  hold_if,
    input  logic                  stall,
    input  logic                  flush,
    output logic [addr_width-1:0] rf_r0addr,
    output logic [addr_width-1:0] rf_r1addr,
    input  logic [data_width-1:0] rf_r0data,
    input  logic [data_width-1:0] rf_r1data,
    input  logic                  wb_wena,
    input  logic [addr_width-1:0] wb_waddr,
    input  logic [data_width-1:0] wb_wdata,
    output logic                  ex_valid,
    output logic [3:0]            ex_op,
    output logic [addr_width-1:0] ex_rd,
    output logic [data_width-1:0] ex_a,
    output logic [data_width-1:0] ex_b,
    output logic [data_width-1:0] ex_imm,
    output logic [pc_width-1:0]   ex_pc,
    output logic                  ex_wena,
    output logic [cnt_width-1:0]  bubble_cnt
);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
        OP_XOR = 4'd5, OP_ADDI = 4'd6, OP_LOAD = 4'd7, OP_STORE = 4'd8, OP_BEQ = 4'd9
    } op_e;

    logic [3:0]            dec_op;
    logic [addr_width-1:0] rd, rs0, rs1;
    logic                  use_rs0, use_rs1, writes_rd, hazard;
    logic [data_width-1:0] opa, opb, imm_ext;

    always_comb begin
        dec_op    = (if_instr[31:28] > OP_BEQ) ? OP_NOP : if_instr[31:28];
        rd        = if_instr[27:24];
        rs0       = if_instr[23:20];
        rs1       = if_instr[19:16];
        use_rs0   = (dec_op != OP_NOP);
        use_rs1   = dec_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE, OP_BEQ};
        writes_rd = (dec_op >= OP_ADD) && (dec_op <= OP_LOAD);
        imm_ext   = {{(data_width-16){if_instr[15]}}, if_instr[15:0]};
        // RF writes on the same edge we capture on, so its read data is stale
        opa       = (wb_wena && wb_waddr == rs0) ? wb_wdata : rf_r0data;
        opb       = (wb_wena && wb_waddr == rs1) ? wb_wdata : rf_r1data;
        hazard    = if_valid && ex_valid && (ex_op == OP_LOAD) &&
                    ((use_rs0 && rs0 == ex_rd) || (use_rs1 && rs1 == ex_rd));
        hold_if   = stall || (hazard && !flush);
    end

    assign rf_r0addr = rs0;
    assign rf_r1addr = rs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_rd      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_wena    <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_wena  <= 1'b0;
            ex_op    <= '0;
        end else if (!stall) begin
            if (hazard) begin
                ex_valid <= 1'b0;
                ex_wena  <= 1'b0;
                ex_op    <= '0;
                if (bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + 1'b1;
            end else begin
                ex_valid <= if_valid;
                ex_wena  <= if_valid && writes_rd;
                ex_op    <= dec_op;
                ex_rd    <= rd;
                ex_a     <= opa;
                ex_b     <= opb;
                ex_imm   <= imm_ext;
                ex_pc    <= if_pc;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, randomized traffic
// against a reference model, reset and bubble-counter saturation sequences.
module tb_operand_fetch_stage;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_wena = 1'b0;
    logic [31:0] if_instr = '0, wb_wdata = '0;
    logic [8:0]  if_pc = '0;
    logic [3:0]  wb_waddr = '0;
    logic [31:0] rf_r0data, rf_r1data;

    logic        hold_if, ex_valid, ex_wena;
    logic [3:0]  rf_r0addr, rf_r1addr, ex_op, ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [8:0]  ex_pc;
    logic [15:0] bubble_cnt;

    logic        s_hold, s_valid, s_wena;
    logic [3:0]  s_r0addr, s_r1addr, s_op, s_rd, s_cnt;
    logic [31:0] s_a, s_b, s_imm, s_r0data, s_r1data;
    logic [8:0]  s_pc;

    logic [31:0] rf [16];
    assign rf_r0data = rf[rf_r0addr];
    assign rf_r1data = rf[rf_r1addr];
    assign s_r0data  = rf[s_r0addr];
    assign s_r1data  = rf[s_r1addr];

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .hold_if(hold_if), .stall(stall), .flush(flush),
        .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr), .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
        .wb_wena(wb_wena), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_wena(ex_wena), .bubble_cnt(bubble_cnt));

    // Narrow counter instance so saturation is reachable in a short run
    operand_fetch_stage #(.cnt_width(4)) dut_sat (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .hold_if(s_hold), .stall(stall), .flush(flush),
        .rf_r0addr(s_r0addr), .rf_r1addr(s_r1addr), .rf_r0data(s_r0data), .rf_r1data(s_r1data),
        .wb_wena(wb_wena), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_valid(s_valid), .ex_op(s_op), .ex_rd(s_rd), .ex_a(s_a), .ex_b(s_b),
        .ex_imm(s_imm), .ex_pc(s_pc), .ex_wena(s_wena), .bubble_cnt(s_cnt));

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model of the ID/EX slot
    logic        m_valid, m_wena, m_opknown;
    logic [3:0]  m_op, m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [8:0]  m_pc;
    int          m_cnt, m_cnts;
    logic        last_hold;

    task automatic model_reset();
        m_valid = 0; m_wena = 0; m_opknown = 1; m_op = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_cnt = 0; m_cnts = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_main"}, {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc, ex_wena, bubble_cnt}, '0);
        chk({nm, "_sat"}, {s_valid, s_op, s_rd, s_a, s_b, s_imm, s_pc, s_wena, s_cnt}, '0);
    endtask

    function automatic logic [31:0] ins(input int op, rd, rs0, rs1, imm);
        return {op[3:0], rd[3:0], rs0[3:0], rs1[3:0], imm[15:0]};
    endfunction

    // One clock: inputs are already applied; checks combinational outputs
    // before the edge and registered outputs after it.
    task automatic cycle();
        logic [3:0]  op, rd, rs0, rs1;
        logic        u0, u1, hz;
        logic [31:0] a, b;
        @(negedge clk);
        op  = if_instr[31:28];
        if (op > 9) op = 0;
        rd  = if_instr[27:24];
        rs0 = if_instr[23:20];
        rs1 = if_instr[19:16];
        u0  = (op != 0);
        u1  = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
        hz  = if_valid && m_valid && m_op == 7 && ((u0 && rs0 == m_rd) || (u1 && rs1 == m_rd));
        last_hold = hold_if;
        chk("hold_if", {hold_if, s_hold}, {2{stall || (hz && !flush)}});
        chk("rf_addr", {rf_r0addr, rf_r1addr, s_r0addr, s_r1addr}, {rs0, rs1, rs0, rs1});
        a = (wb_wena && wb_waddr == rs0) ? wb_wdata : rf[rs0];
        b = (wb_wena && wb_waddr == rs1) ? wb_wdata : rf[rs1];
        @(posedge clk);
        #1;
        if (wb_wena) rf[wb_waddr] = wb_wdata;
        if (flush || (!stall && hz)) begin
            m_valid = 0; m_wena = 0; m_op = 0; m_opknown = 1;
            if (!flush) begin
                m_cnt  = (m_cnt  == 65535) ? 65535 : m_cnt + 1;
                m_cnts = (m_cnts == 15)    ? 15    : m_cnts + 1;
            end
        end else if (!stall) begin
            m_valid = if_valid; m_op = op; m_opknown = if_valid; m_rd = rd;
            m_wena = if_valid && op >= 1 && op <= 7;
            m_a = a; m_b = b; m_imm = 32'($signed(if_instr[15:0])); m_pc = if_pc;
        end
        chk("ex_valid_wena", {ex_valid, ex_wena, s_valid, s_wena}, {2{m_valid, m_wena}});
        if (m_opknown) chk("ex_op", {ex_op, s_op}, {2{m_op}});
        if (m_valid)
            chk("ex_data", {ex_rd, ex_a, ex_b, ex_imm, ex_pc}, {m_rd, m_a, m_b, m_imm, m_pc});
        if (m_valid)
            chk("ex_data_sat", {s_rd, s_a, s_b, s_imm, s_pc}, {m_rd, m_a, m_b, m_imm, m_pc});
        chk("bubble_cnt", {bubble_cnt, s_cnt}, {m_cnt[15:0], m_cnts[3:0]});
    endtask

    typedef struct {
        logic        vld, stl, fls, we;
        logic [31:0] instr;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        e_hold, e_valid, e_wena, dchk;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b, e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic vld, stl, fls, we, input logic [31:0] instr,
                                input logic [3:0] wa, input logic [31:0] wd,
                                input logic e_hold, e_valid, e_wena, dchk,
                                input logic [3:0] e_op, input logic [31:0] e_a, e_b, e_imm,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.vld = vld; v.stl = stl; v.fls = fls; v.we = we; v.instr = instr; v.wa = wa; v.wd = wd;
        v.e_hold = e_hold; v.e_valid = e_valid; v.e_wena = e_wena; v.dchk = dchk;
        v.e_op = e_op; v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vt [14];

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = (i == 0) ? 32'd0 : 32'((i - 1) * 10);
        model_reset();
        #1;
        chk_zero("reset_initial");
        @(posedge clk); #1;
        rst = 0;

        //            vld stl fls we instr                          wa wd     hold vld wen dchk op a      b      imm          cnt
        vt[0]  = mk(1, 0, 0, 0, ins(1, 1, 2, 3, 0),          0, 0,     0, 1, 1, 1, 1, 10,    20,    0,           0);
        vt[1]  = mk(1, 0, 0, 1, ins(1, 4, 2, 3, 0),          3, 'h55,  0, 1, 1, 1, 1, 10,    'h55,  0,           0);
        vt[2]  = mk(1, 0, 0, 0, ins(7, 5, 2, 0, 4),          0, 0,     0, 1, 1, 1, 7, 10,    0,     4,           0);
        vt[3]  = mk(1, 0, 0, 0, ins(2, 6, 1, 5, 0),          0, 0,     1, 0, 0, 0, 0, 0,     0,     0,           1);
        vt[4]  = mk(1, 0, 0, 0, ins(2, 6, 1, 5, 0),          0, 0,     0, 1, 1, 1, 2, 0,     40,    0,           1);
        vt[5]  = mk(1, 0, 0, 0, ins(7, 5, 2, 0, 0),          0, 0,     0, 1, 1, 1, 7, 10,    0,     0,           1);
        vt[6]  = mk(1, 0, 0, 0, ins(6, 7, 3, 5, 'hFFFE),     0, 0,     0, 1, 1, 1, 6, 'h55,  40,    'hFFFFFFFE,  1);
        vt[7]  = mk(1, 1, 0, 0, ins(1, 8, 7, 7, 0),          0, 0,     1, 1, 1, 1, 6, 'h55,  40,    'hFFFFFFFE,  1);
        vt[8]  = mk(1, 1, 0, 0, ins(1, 8, 7, 7, 0),          0, 0,     1, 1, 1, 1, 6, 'h55,  40,    'hFFFFFFFE,  1);
        vt[9]  = mk(1, 1, 0, 0, ins(1, 8, 7, 7, 0),          0, 0,     1, 1, 1, 1, 6, 'h55,  40,    'hFFFFFFFE,  1);
        vt[10] = mk(1, 0, 0, 0, ins(1, 8, 7, 7, 0),          0, 0,     0, 1, 1, 1, 1, 60,    60,    0,           1);
        vt[11] = mk(1, 0, 0, 0, ins(7, 9, 2, 0, 0),          0, 0,     0, 1, 1, 1, 7, 10,    0,     0,           1);
        vt[12] = mk(1, 0, 1, 0, ins(1, 1, 9, 0, 0),          0, 0,     0, 0, 0, 0, 0, 0,     0,     0,           1);
        vt[13] = mk(0, 0, 0, 0, ins(1, 1, 2, 3, 0),          0, 0,     0, 0, 0, 0, 0, 0,     0,     0,           1);

        for (int i = 0; i < 14; i++) begin
            if_valid = vt[i].vld; stall = vt[i].stl; flush = vt[i].fls; wb_wena = vt[i].we;
            if_instr = vt[i].instr; wb_waddr = vt[i].wa; wb_wdata = vt[i].wd; if_pc = 9'(i + 100);
            cycle();
            chk($sformatf("vec%0d_hold", i), last_hold, vt[i].e_hold);
            chk($sformatf("vec%0d_ctl", i), {ex_valid, ex_wena, bubble_cnt},
                {vt[i].e_valid, vt[i].e_wena, vt[i].e_cnt});
            if (vt[i].vld) chk($sformatf("vec%0d_op", i), ex_op, vt[i].e_op);
            if (vt[i].dchk)
                chk($sformatf("vec%0d_data", i), {ex_a, ex_b, ex_imm}, {vt[i].e_a, vt[i].e_b, vt[i].e_imm});
        end

        // Randomized traffic with a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            if_valid = ($urandom_range(0, 99) < 85);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            wb_wena  = $urandom_range(0, 1);
            wb_waddr = 4'($urandom_range(0, 3));
            wb_wdata = $urandom;
            if_pc    = 9'($urandom);
            if_instr = ($urandom_range(0, 3) == 0)
                       ? ins(7, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom)
                       : ins($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom);
            cycle();
        end

        // Reset while a live instruction sits in ID/EX
        stall = 0; flush = 0; wb_wena = 0; if_valid = 1; if_instr = ins(0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("pre_reset_valid", ex_valid, 1'b1);
        rst = 1;
        #1;
        chk_zero("reset_midstream");
        @(posedge clk); #1;
        chk_zero("reset_held");
        rst = 0;
        model_reset();

        // Self-dependent load: alternates load capture and bubble
        if_instr = ins(7, 5, 5, 0, 0);
        for (int i = 0; i < 40; i++) cycle();
        chk("sat_cnt_narrow", s_cnt, 4'hF);
        chk("sat_cnt_wide", bubble_cnt, 16'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
